// File: rtl/layer1_maxpool_2x2.sv
// layer1_maxpool_2x2: two-stage signed 2x2 max-pool over CH channels with valid/ready
// handshakes, pooled row/column tagging and a done pulse per OUT_H x OUT_W frame.
module layer1_maxpool_2x2 #(
  parameter int CH    = 32,
  parameter int DW    = 32,
  parameter int OUT_H = 17,
  parameter int OUT_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [CH*4*DW-1:0] window_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CH*DW-1:0]  pool_out,
  output logic [4:0]        row_idx,
  output logic [3:0]        col_idx,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CW = $clog2(OUT_H*OUT_W+1);
  localparam logic [CW-1:0] N = CW'(OUT_H*OUT_W);
  localparam logic [4:0] LR = 5'(OUT_H-1);
  localparam logic [3:0] LC = 4'(OUT_W-1);
  state_t state;
  logic [CW-1:0] in_cnt;
  logic s1_valid, stall, accept, out_hs, last_col, frame_end;
  logic [CH*DW-1:0] s1_a, s1_b, s1_a_d, s1_b_d, pool_d;
  function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return $signed(a) > $signed(b) ? a : b;
  endfunction
  assign stall     = valid_out && !ready_in;
  assign ready_out = !stall && state != DONE && in_cnt < N;
  assign accept    = valid_in && ready_out;
  assign out_hs    = valid_out && ready_in;
  assign last_col  = col_idx == LC;
  assign frame_end = out_hs && last_col && row_idx == LR;
  always_comb begin
    s1_a_d = '0;
    s1_b_d = '0;
    pool_d = '0;
    for (int c = 0; c < CH; c++) begin
      s1_a_d[c*DW +: DW] = smax(window_in[(c*4)*DW +: DW], window_in[(c*4+1)*DW +: DW]);
      s1_b_d[c*DW +: DW] = smax(window_in[(c*4+2)*DW +: DW], window_in[(c*4+3)*DW +: DW]);
      pool_d[c*DW +: DW] = smax(s1_a[c*DW +: DW], s1_b[c*DW +: DW]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_cnt    <= '0;
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      valid_out <= 1'b0;
      pool_out  <= '0;
      row_idx   <= '0;
      col_idx   <= '0;
      done      <= 1'b0;
    end else begin
      // the whole pipeline freezes while the output is held, so nothing is lost or repeated
      if (!stall) begin
        s1_valid  <= accept;
        valid_out <= s1_valid;
        if (accept) begin
          s1_a <= s1_a_d;
          s1_b <= s1_b_d;
        end
        if (s1_valid) pool_out <= pool_d;
      end
      if (out_hs) begin
        col_idx <= last_col ? '0 : col_idx + 1'b1;
        row_idx <= !last_col ? row_idx : frame_end ? '0 : row_idx + 1'b1;
      end
      in_cnt <= state == DONE ? '0 : accept ? in_cnt + 1'b1 : in_cnt;
      state  <= frame_end ? DONE : state == DONE ? IDLE : (state == IDLE && accept) ? RUN : state;
      done   <= frame_end;
    end
  end
endmodule

// File: doc/layer1_maxpool_2x2.md
Name: layer1_maxpool_2x2

Overview:
- Downstream consumer of the layer-1 mid buffer.
- Accepts one 2x2 window per channel per beat (32 channels, 32-bit signed data) and reduces each window to its maximum.
- Streams the pooled pixels out with valid/ready, tagged by output row/column, and pulses done after a full 17x13 pooled frame.
- Output feeds the layer-2 input buffer.

Parameters:
- CH, 32, number of channels processed in parallel.
- DW, 32, data width per element, two's-complement signed.
- OUT_H, 17, pooled rows per frame (34/2).
- OUT_W, 13, pooled columns per frame (26/2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  window_in holds a valid window set.
- ready_out  out  1  block accepts a window this cycle.
- window_in  in  CH*4*DW  channel c, element (r,k) at bits [(c*4+r*2+k)*DW +: DW]; r,k in {0,1}.
- valid_out  out  1  pool_out valid.
- ready_in  in  1  downstream accepts pool_out.
- pool_out  out  CH*DW  channel c max at bits [c*DW +: DW].
- row_idx  out  5  pooled row of current pool_out, 0..OUT_H-1.
- col_idx  out  4  pooled column of current pool_out, 0..OUT_W-1.
- done  out  1  one-cycle pulse after the last pixel of a frame is handshaken.

Behaviour:
- Reset (async, rst_n=0): valid_out=0, pool_out=0, row_idx=0, col_idx=0, done=0, pipeline valids cleared, in_cnt=0, FSM=IDLE. Reset mid-frame discards all in-flight data; nothing further is emitted from that frame.
- Input handshake: a window is accepted when valid_in && ready_out.
- Output handshake: a pixel transfers when valid_out && ready_in.
- Pipeline: two stages.
  - S1 registers max(e00,e01) and max(e10,e11) per channel.
  - S2 registers max of the two S1 values into pool_out.
  - Latency is 2 cycles from accept to valid_out with no stall.
  - Throughput is 1 window per cycle.
- Compare rule: signed compare. On equal values either operand is taken; the result value is identical.
- Stall: stall = valid_out && !ready_in. On stall, S1 and S2 hold their contents. pool_out, row_idx and col_idx stay stable until the output handshake.
- ready_out is 1 only when all of the following hold: not stalled, FSM != DONE, and in_cnt < OUT_H*OUT_W. The input counter saturates per frame; extra windows are back-pressured, not dropped.
- Bubbles: an S1 bubble propagates so that valid_out falls when no data is present. No pixel is duplicated or skipped.
- Output counter: advances on each output handshake.
  - col_idx increments.
  - At col_idx=OUT_W-1, col_idx wraps to 0 and row_idx increments.
- Frame end: on the handshake of (row OUT_H-1, col OUT_W-1):
  - row_idx and col_idx return to 0.
  - FSM goes to DONE.
  - done=1 for exactly the next cycle.
- FSM:
  - IDLE to RUN on first accepted window.
  - RUN to DONE on the last output handshake.
  - DONE to IDLE after one cycle; in_cnt clears to 0 on leaving DONE.
  - ready_out=0 in DONE, so the next frame's first window is accepted no earlier than the cycle after done.
- Simultaneous accept and output handshake in the same cycle are both honoured; the pipeline advances normally.

Test Plan:
- Basic max: ch0 window {5,-3,9,2}, ch31 {-7,-1,-4,-8}, valid_in for 1 cycle, ready_in=1 -> valid_out exactly 2 cycles later for 1 cycle, pool_out ch0=9, ch31=-1 (0xFFFFFFFF), row_idx=0, col_idx=0.
- Signed extremes: window {0x80000000,0x7FFFFFFF,0,0xFFFFFFFF} on all channels -> every channel outputs 0x7FFFFFFF.
- Backpressure: stream 10 windows, hold ready_in=0 for cycles 3..7 -> pool_out stable while stalled, ready_out=0 while stalled, all 10 outputs appear in order, no loss or duplication.
- Full frame: 221 random windows with valid_in=1 and ready_in=1 -> 221 outputs matching a reference model.
  - col_idx wraps 12->0 with row_idx incrementing.
  - Last output at row 16, col 12.
  - done pulses once, 1 cycle after the last handshake.
  - ready_out=0 after the 221st accept until the cycle after done.
- Overrun: hold valid_in=1 for 230 cycles -> only 221 accepted in the frame, window 222 accepted only after done, counters restart at 0,0.
- Reset mid-frame: assert rst_n=0 after 50 accepts with 2 in flight -> valid_out and done drop immediately, counters 0. After release, a new frame of 221 completes normally with done pulse.
